// File: rtl/uart_rx_os16_if.sv
// Parallel/serial signal bundle of the 16x-oversampling UART receiver.
// master = line driver and byte consumer, slave = receiver.
interface uart_rx_os16_if;
  logic       rx_enable;
  logic       rx_in;
  logic       rd_ack;
  logic [7:0] data_out;
  logic       data_ready;
  logic       rx_busy;
  logic       rx_error;
  logic       rx_overrun;

  modport master (
    output rx_enable, rx_in, rd_ack,
    input  data_out, data_ready, rx_busy, rx_error, rx_overrun
  );

  modport slave (
    input  rx_enable, rx_in, rd_ack,
    output data_out, data_ready, rx_busy, rx_error, rx_overrun
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver clocked from system clk, ready/ack byte port.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_os16 #(
  parameter int OS_DIV     = 27,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rx_reset,
  uart_rx_os16_if.slave bus
);

  if (OS_DIV < 2 || OS_DIV > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_os16: OS_DIV must be 2..65535 and PARITY_ODD 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] TICK_LAST = 16'(OS_DIV - 1);

  state_t      state;
  logic [1:0]  sync;
  logic        rx_s;
  logic [15:0] tick_cnt;
  logic        os_tick;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        s6;
  logic        s7;
  logic        maj;
  logic        parity_err;

  logic [7:0]  data_out;
  logic        data_ready;
  logic        rx_busy;
  logic        rx_error;
  logic        rx_overrun;

  assign bus.data_out   = data_out;
  assign bus.data_ready = data_ready;
  assign bus.rx_busy    = rx_busy;
  assign bus.rx_error   = rx_error;
  assign bus.rx_overrun = rx_overrun;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rx_reset) begin
    if (rx_reset) sync <= 2'b11;
    else          sync <= {sync[0], bus.rx_in};
  end

  assign rx_s = sync[1];

  // Oversample tick generator; parked at 0 while idle so each frame starts phase-aligned.
  assign os_tick = (state != IDLE) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rx_reset) begin
    if (rx_reset)            tick_cnt <= '0;
    else if (state == IDLE)  tick_cnt <= '0;
    else if (os_tick)        tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 16'd1;
  end

  // Counts 6 and 7 are latched; the vote is resolved on the count-8 tick with the live sample.
  assign maj = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rx_reset) begin
    if (rx_reset) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      s6         <= 1'b1;
      s7         <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      data_out   <= '0;
      data_ready <= 1'b0;
      rx_busy    <= 1'b0;
      rx_error   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (bus.rd_ack && data_ready) begin
        data_ready <= 1'b0;
        rx_overrun <= 1'b0;
      end

      if (state == IDLE) begin
        if (bus.rx_enable && !rx_s) begin
          state   <= START;
          rx_busy <= 1'b1;
          os_cnt  <= '0;
          bit_cnt <= '0;
        end
      end else if (!bus.rx_enable) begin
        state   <= IDLE;
        rx_busy <= 1'b0;
      end else if (os_tick) begin
        os_cnt <= os_cnt + 4'd1;
        if (os_cnt == 4'd6) s6 <= rx_s;
        if (os_cnt == 4'd7) s7 <= rx_s;

        case (state)
          START: begin
            if (os_cnt == 4'd7 && rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else if (os_cnt == 4'd15) begin
              state <= DATA;
            end
          end

          DATA: begin
            if (os_cnt == 4'd8) begin
              shift_reg <= {maj, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (os_cnt == 4'd8) begin
              parity_err <= maj != ((^shift_reg) ^ 1'(PARITY_ODD));
              state      <= STOP;
            end
          end
`endif

          STOP: begin
            if (os_cnt == 4'd8) begin
              data_out   <= shift_reg;
              data_ready <= 1'b1;
              rx_error   <= !maj | parity_err;
              // An ack landing on the completion edge consumes the old byte, so no overrun.
              if (data_ready && !bus.rd_ack) rx_overrun <= 1'b1;
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end

          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
